trellis_bank_sched: RTL and testbench

Controller for the four-bank trellis (survivor) memory of the Viterbi decoder. It sequences the write/traceback rotation across banks A–D and generates per-bank write enables and addresses. It also produces the delayed bank index used for traceback-input muxing, the traceback-unit enables and selections, and a frame strobe. It sits between the ACS register stage and the trellis mem instances, replacing ad-hoc counter and case logic, and adds a symbol-valid stall.

---
 rtl/trellis_bank_sched.sv | 111 +++++++++++
 tb/tb_trellis_bank_sched.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/trellis_bank_sched.sv
// Write/traceback bank rotation controller for the four-bank Viterbi survivor memory.
// Generates one-hot bank writes, per-bank addresses, traceback bank alignment and TBU controls.
module trellis_bank_sched #(
   parameter int AW = 10
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            enable,
   input  logic            sym_valid,
   output logic [3:0]      bank_we,
   output logic [4*AW-1:0] bank_addr,
   output logic [1:0]      wr_bank,
   output logic [1:0]      tb_bank,
   output logic [1:0]      tbu_sel,
   output logic [1:0]      tbu_en,
   output logic            frame_pulse
);

   logic [AW-1:0]   wr_cnt_q, wr_cnt_d;
   logic [AW-1:0]   rd_cnt;
   logic [1:0]      wr_bank_q, wr_bank_d;
   logic [1:0]      tb_mid_q, tb_mid_d;
   logic [1:0]      tb_bank_q, tb_bank_d;
   logic [3:0]      bank_we_q, bank_we_d;
   logic [4*AW-1:0] bank_addr_q, bank_addr_d;
   logic [1:0]      tbu_en_q, tbu_en_d;
   logic            frame_pulse_q, frame_pulse_d;
   logic [4*AW-1:0] role_addr;
   logic            adv;
   logic            wrap;

   assign adv    = enable & sym_valid;
   assign wrap   = adv & (wr_cnt_q == {AW{1'b1}});
   // The read counter sweeps the frame backwards, so it is simply the complement.
   assign rd_cnt = ~wr_cnt_q;

   // Address by role relative to the bank being written: write, two traceback reads, idle.
   always_comb begin
      logic [1:0] rel;
      role_addr = '0;
      rel       = 2'd0;
      for (int i = 0; i < 4; i++) begin
         rel = 2'(i) - wr_bank_q;
         case (rel)
            2'd0:    role_addr[i*AW +: AW] = wr_cnt_q;
            2'd2:    role_addr[i*AW +: AW] = '0;
            default: role_addr[i*AW +: AW] = rd_cnt;
         endcase
      end
   end

   always_comb begin
      wr_cnt_d      = wr_cnt_q;
      wr_bank_d     = wr_bank_q;
      tb_mid_d      = tb_mid_q;
      tb_bank_d     = tb_bank_q;
      bank_we_d     = '0;
      bank_addr_d   = bank_addr_q;
      tbu_en_d      = tbu_en_q;
      frame_pulse_d = 1'b0;

      if (!enable) begin
         wr_cnt_d = '0;
         tbu_en_d = '0;
      end else begin
         // Traceback bank chain is frozen while disabled, otherwise follows wr_bank by two.
         tb_mid_d  = wr_bank_q;
         tb_bank_d = tb_mid_q;
         if (tb_bank_q == 2'd2) tbu_en_d[0] = 1'b1;
         if (tb_bank_q == 2'd3) tbu_en_d[1] = 1'b1;
         if (sym_valid) begin
            wr_cnt_d      = wr_cnt_q + 1'b1;
            bank_we_d     = 4'b0001 << wr_bank_q;
            bank_addr_d   = role_addr;
            frame_pulse_d = wrap;
            if (wrap) wr_bank_d = wr_bank_q + 2'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_cnt_q      <= '0;
         wr_bank_q     <= 2'd0;
         tb_mid_q      <= 2'd0;
         tb_bank_q     <= 2'd0;
         bank_we_q     <= '0;
         bank_addr_q   <= '0;
         tbu_en_q      <= 2'b00;
         frame_pulse_q <= 1'b0;
      end else begin
         wr_cnt_q      <= wr_cnt_d;
         wr_bank_q     <= wr_bank_d;
         tb_mid_q      <= tb_mid_d;
         tb_bank_q     <= tb_bank_d;
         bank_we_q     <= bank_we_d;
         bank_addr_q   <= bank_addr_d;
         tbu_en_q      <= tbu_en_d;
         frame_pulse_q <= frame_pulse_d;
      end
   end

   assign bank_we     = bank_we_q;
   assign bank_addr   = bank_addr_q;
   assign wr_bank     = wr_bank_q;
   assign tb_bank     = tb_bank_q;
   assign tbu_sel     = {~tb_bank_q[0], tb_bank_q[0]};
   assign tbu_en      = tbu_en_q;
   assign frame_pulse = frame_pulse_q;

endmodule

// File: tb/tb_trellis_bank_sched.sv
// Bench for trellis_bank_sched: directed scenarios with literal checks plus randomized
// enable/valid traffic compared every cycle against a frame-level behavioural model.
module tb_trellis_bank_sched;

   localparam int AW = 4;
   localparam int N  = 1 << AW;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            enable = 1'b0;
   logic            sym_valid = 1'b0;
   logic [3:0]      bank_we;
   logic [4*AW-1:0] bank_addr;
   logic [1:0]      wr_bank;
   logic [1:0]      tb_bank;
   logic [1:0]      tbu_sel;
   logic [1:0]      tbu_en;
   logic            frame_pulse;

   int n_chk  = 0;
   int n_fail = 0;
   bit cmp_en = 0;

   trellis_bank_sched #(.AW(AW)) dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .sym_valid   (sym_valid),
      .bank_we     (bank_we),
      .bank_addr   (bank_addr),
      .wr_bank     (wr_bank),
      .tb_bank     (tb_bank),
      .tbu_sel     (tbu_sel),
      .tbu_en      (tbu_en),
      .frame_pulse (frame_pulse)
   );

   always #5 clk = ~clk;

   // Behavioural model: symbol count within frame, bank index, two-step bank history.
   int m_cnt  = 0;
   int m_wr   = 0;
   int m_mid  = 0;
   int m_tb   = 0;
   int m_we   = 0;
   int m_addr [4] = '{0, 0, 0, 0};
   bit m_tbu0 = 0;
   bit m_tbu1 = 0;
   bit m_fp   = 0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_cnt = 0; m_wr = 0; m_mid = 0; m_tb = 0; m_we = 0;
         for (int i = 0; i < 4; i++) m_addr[i] = 0;
         m_tbu0 = 0; m_tbu1 = 0; m_fp = 0;
      end else if (!enable) begin
         m_cnt = 0; m_we = 0; m_fp = 0; m_tbu0 = 0; m_tbu1 = 0;
      end else begin
         if (m_tb == 2) m_tbu0 = 1;
         if (m_tb == 3) m_tbu1 = 1;
         m_tb  = m_mid;
         m_mid = m_wr;
         if (sym_valid) begin
            m_we = 1 << m_wr;
            m_addr[m_wr]         = m_cnt;
            m_addr[(m_wr+1) % 4] = N - 1 - m_cnt;
            m_addr[(m_wr+3) % 4] = N - 1 - m_cnt;
            m_addr[(m_wr+2) % 4] = 0;
            m_fp  = (m_cnt == N - 1);
            m_cnt = (m_cnt + 1) % N;
            if (m_fp) m_wr = (m_wr + 1) % 4;
         end else begin
            m_we = 0;
            m_fp = 0;
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [4*AW-1:0] model_addr();
      logic [4*AW-1:0] v;
      v = '0;
      for (int i = 0; i < 4; i++) v[i*AW +: AW] = AW'(m_addr[i]);
      return v;
   endfunction

   // Scoreboard: every cycle, all outputs against the model.
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("m_bank_we", 64'(bank_we), 64'(m_we));
         chk("m_bank_addr", 64'(bank_addr), 64'(model_addr()));
         chk("m_wr_bank", 64'(wr_bank), 64'(m_wr));
         chk("m_tb_bank", 64'(tb_bank), 64'(m_tb));
         chk("m_tbu_sel", 64'(tbu_sel), (m_tb % 2 == 1) ? 64'd1 : 64'd2);
         chk("m_tbu_en", 64'(tbu_en), 64'({m_tbu1, m_tbu0}));
         chk("m_frame_pulse", 64'(frame_pulse), 64'(m_fp));
         if (bank_we & (bank_we - 4'd1)) chk("onehot", 64'(bank_we), 64'd0);
      end
   end

   initial begin
      // Reset and idle with enable low
      repeat (2) @(negedge clk);
      cmp_en = 1;
      rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("rst_we", 64'(bank_we), 64'd0);
         chk("rst_sel", 64'(tbu_sel), 64'd2);
      end
      chk("rst_addr", 64'(bank_addr), 64'd0);
      chk("rst_tbu_en", 64'(tbu_en), 64'd0);

      // Fill bank A
      enable = 1'b1; sym_valid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         chk("fill_we", 64'(bank_we), 64'h1);
         chk("fill_a", 64'(bank_addr[3:0]), 64'(i));
         chk("fill_b", 64'(bank_addr[7:4]), 64'(15 - i));
         chk("fill_c", 64'(bank_addr[11:8]), 64'd0);
         chk("fill_d", 64'(bank_addr[15:12]), 64'(15 - i));
         chk("fill_fp", 64'(frame_pulse), 64'(i == 15));
      end
      chk("fill_wr_bank", 64'(wr_bank), 64'd1);
      @(negedge clk);
      chk("b_we", 64'(bank_we), 64'h2);
      chk("b_addr0", 64'(bank_addr[7:4]), 64'd0);
      chk("b_fp", 64'(frame_pulse), 64'd0);

      // Stall pattern 1,0,0,1 starting at wr_cnt=5
      repeat (4) @(negedge clk);
      @(negedge clk);
      chk("st_we1", 64'(bank_we), 64'h2);
      chk("st_addr1", 64'(bank_addr[7:4]), 64'd5);
      sym_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("st_we0", 64'(bank_we), 64'h0);
         chk("st_hold", 64'(bank_addr[7:4]), 64'd5);
      end
      sym_valid = 1'b1;
      @(negedge clk);
      chk("st_we2", 64'(bank_we), 64'h2);
      chk("st_addr2", 64'(bank_addr[7:4]), 64'd6);
      for (int j = 0; j < 9; j++) begin
         @(negedge clk);
         chk("st_fp", 64'(frame_pulse), 64'(j == 8));
      end
      chk("tb_wr2", 64'(wr_bank), 64'd2);

      // Traceback bank alignment and sticky TBU enables
      @(negedge clk);
      chk("tb_e1", 64'(tb_bank), 64'd1);
      @(negedge clk);
      chk("tb_e2", 64'(tb_bank), 64'd2);
      chk("tb_sel2", 64'(tbu_sel), 64'd2);
      chk("tb_en_e2", 64'(tbu_en), 64'd0);
      @(negedge clk);
      chk("tb_en01", 64'(tbu_en), 64'd1);
      for (int j = 0; j < 13; j++) begin
         @(negedge clk);
         chk("tb_fp", 64'(frame_pulse), 64'(j == 12));
      end
      @(negedge clk);
      @(negedge clk);
      chk("tb_bank3", 64'(tb_bank), 64'd3);
      chk("tb_sel3", 64'(tbu_sel), 64'd1);
      @(negedge clk);
      chk("tb_en11", 64'(tbu_en), 64'd3);

      // Enable drop at wr_cnt=9 in bank D
      repeat (6) @(negedge clk);
      enable = 1'b0;
      @(negedge clk);
      chk("en_we", 64'(bank_we), 64'd0);
      chk("en_tbu", 64'(tbu_en), 64'd0);
      chk("en_wr", 64'(wr_bank), 64'd3);
      chk("en_addr", 64'(bank_addr[15:12]), 64'd8);
      @(negedge clk);
      enable = 1'b1;
      @(negedge clk);
      chk("re_we", 64'(bank_we), 64'h8);
      chk("re_addr", 64'(bank_addr[15:12]), 64'd0);

      // Asynchronous reset between edges
      repeat (3) @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("ar_we", 64'(bank_we), 64'd0);
      chk("ar_addr", 64'(bank_addr), 64'd0);
      chk("ar_wr", 64'(wr_bank), 64'd0);
      chk("ar_tb", 64'(tb_bank), 64'd0);
      chk("ar_tbu", 64'(tbu_en), 64'd0);
      chk("ar_sel", 64'(tbu_sel), 64'd2);
      chk("ar_fp", 64'(frame_pulse), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("ar_first_we", 64'(bank_we), 64'h1);
      chk("ar_first_addr", 64'(bank_addr[3:0]), 64'd0);

      // Randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         enable    = ($urandom_range(0, 99) < 96);
         sym_valid = ($urandom_range(0, 3) != 0);
         @(negedge clk);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
